wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//   Round-robin arbiter sharing one pipelined Wishbone target among ITR_CNT
//   initiators. Owns bus-cycle control only: grant, cyc/stb/lock gating,
//   stall and response routing. Address/data muxing sits in a separate mux
//   block steered by gnt_o. Used on each target port of the crossbar.
// PARAMETERS
//   ITR_CNT     4  number of initiators (>=2)
//   OUTSTD_MAX  4  max accepted-but-unacknowledged accesses on target (>=1)
// PORTS
//   clk_i        in   1        module clock
//   async_rst_i  in   1        asynchronous reset, active-high
//   sync_rst_i   in   1        synchronous reset, active-high
//   itr_cyc_i    in   ITR_CNT  bus cycle indicators
//   itr_stb_i    in   ITR_CNT  access requests
//   itr_lock_i   in   ITR_CNT  uninterruptable bus cycle
//   itr_ack_o    out  ITR_CNT  acknowledge, routed to grantee
//   itr_err_o    out  ITR_CNT  error, routed to grantee
//   itr_rty_o    out  ITR_CNT  retry, routed to grantee
//   itr_stall_o  out  ITR_CNT  access delay
//   tgt_cyc_o    out  1        bus cycle indicator to target
//   tgt_stb_o    out  1        access request to target
//   tgt_lock_o   out  1        lock to target
//   tgt_ack_i    in   1        target acknowledge
//   tgt_err_i    in   1        target error
//   tgt_rty_i    in   1        target retry
//   tgt_stall_i  in   1        target stall
//   gnt_o        out  ITR_CNT  one-hot grant (all-zero when idle), registered
// BEHAVIOUR
//   Clock clk_i; reset async_rst_i asynchronous active-high; sync_rst_i has
//   identical effect on next clk_i edge. Reset: state=IDLE, gnt_o=0, cnt=0,
//   last=ITR_CNT-1 (initiator 0 highest priority first). All outputs derive
//   from state -> in reset tgt_cyc/stb/lock_o=0, itr_stall_o=all-1, responses 0.
//   States: IDLE, BUSY.
//   IDLE: tgt_cyc_o=0; if any itr_cyc_i, pick first asserted index searching
//     last+1, last+2, ... (mod ITR_CNT); set gnt_o one-hot, last=pick, ->BUSY.
//     Arbitration latency 1 cycle: grantee sees stall_o=1 in request cycle.
//   BUSY (grantee g): tgt_cyc_o=itr_cyc_i[g]; tgt_lock_o=itr_lock_i[g];
//     full=(cnt==OUTSTD_MAX); tgt_stb_o=itr_cyc_i[g]&itr_stb_i[g]&~full;
//     itr_stall_o[g]=tgt_stall_i|full; itr_stall_o[others]=1;
//     itr_ack/err/rty_o[g]=tgt_ack/err/rty_i; others 0.
//   Counter cnt, width $clog2(OUTSTD_MAX+1): acc=tgt_cyc_o&tgt_stb_o&~tgt_stall_i,
//     rsp=tgt_ack_i|tgt_err_i|tgt_rty_i. acc&~rsp: +1; rsp&~acc: -1; both: hold.
//     rsp at cnt==0: forwarded, cnt stays 0 (no underflow). Never exceeds max.
//   Release: itr_cyc_i[g] low in BUSY -> next cycle IDLE, gnt_o=0, cnt=0;
//     outstanding responses abandoned; target responses while IDLE dropped.
//   No preemption: grant held while itr_cyc_i[g] high, lock or not; lock is
//     passed through only (lock semantics enforced by initiator holding cyc).
//   Re-grant: released initiator gets lowest priority in next IDLE arbitration;
//     minimum one IDLE cycle between consecutive grants.
//   Reset mid-cycle: immediate IDLE, grant lost, cnt=0; no responses routed.
// TESTING
//   Reset, all cyc=0 -> gnt_o=0, tgt_cyc_o=0, itr_stall_o=4'b1111 throughout.
//   itr_cyc_i=4'b1010 from IDLE after reset -> gnt_o=4'b0010 next cycle; after
//     release with cyc=4'b1010 held -> gnt_o=4'b1000, then 4'b0010 again.
//   Grantee issues 6 back-to-back stb, tgt_stall_i=0, no acks, OUTSTD_MAX=4
//     -> 4 accepted, itr_stall_o[g]=1 with cnt=4; one ack -> 5th accepted.
//   Same-cycle accept and ack at cnt=2 -> cnt stays 2; spurious ack at cnt=0
//     -> forwarded to grantee, cnt stays 0.
//   Grantee drops cyc with cnt=3 -> IDLE next cycle, cnt=0; late tgt_ack_i
//     -> all itr_ack_o=0.
//   async_rst_i pulsed mid-BUSY (between clock edges) -> gnt_o=0,
//     tgt_cyc_o=0 immediately; sync_rst_i -> same at next edge.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus-cycle arbiter for one pipelined Wishbone target: grant, cyc/stb/lock gating, response routing.
// Grant is registered one cycle after the request; the grantee is stalled by the target or when OUTSTD_MAX accesses are unacknowledged.
module wb_rr_arbiter #(
    parameter int ITR_CNT    = 4,
    parameter int OUTSTD_MAX = 4
) (
    input  logic               clk_i,
    input  logic               async_rst_i,
    input  logic               sync_rst_i,
    input  logic [ITR_CNT-1:0] itr_cyc_i,
    input  logic [ITR_CNT-1:0] itr_stb_i,
    input  logic [ITR_CNT-1:0] itr_lock_i,
    output logic [ITR_CNT-1:0] itr_ack_o,
    output logic [ITR_CNT-1:0] itr_err_o,
    output logic [ITR_CNT-1:0] itr_rty_o,
    output logic [ITR_CNT-1:0] itr_stall_o,
    output logic               tgt_cyc_o,
    output logic               tgt_stb_o,
    output logic               tgt_lock_o,
    input  logic               tgt_ack_i,
    input  logic               tgt_err_i,
    input  logic               tgt_rty_i,
    input  logic               tgt_stall_i,
    output logic [ITR_CNT-1:0] gnt_o
);

    localparam int IW = $clog2(ITR_CNT);
    localparam int CW = $clog2(OUTSTD_MAX + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(ITR_CNT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTD_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ITR_CNT-1:0] gnt, gnt_nxt;
    logic [IW-1:0]      last, last_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      cand;
    logic               pick_vld;
    logic               full;
    logic               acc;
    logic               rsp;

    // While BUSY, last always holds the grantee index.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= LAST_RST;
            cnt   <= '0;
        end else if (sync_rst_i) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= LAST_RST;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Walk downward so the nearest requester after last wins.
    always_comb begin
        pick     = last;
        cand     = last;
        pick_vld = 1'b0;
        for (int i = ITR_CNT; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % ITR_CNT);
            if (itr_cyc_i[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign acc = tgt_cyc_o & tgt_stb_o & ~tgt_stall_i;
    assign rsp = tgt_ack_i | tgt_err_i | tgt_rty_i;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = BUSY;
                    gnt_nxt   = {{(ITR_CNT-1){1'b0}}, 1'b1} << pick;
                    last_nxt  = pick;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!itr_cyc_i[last]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (acc && !rsp) begin
                    cnt_nxt = cnt + CW'(1);
                end else if (rsp && !acc && (cnt != '0)) begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tgt_cyc_o   = 1'b0;
        tgt_stb_o   = 1'b0;
        tgt_lock_o  = 1'b0;
        itr_stall_o = '1;
        itr_ack_o   = '0;
        itr_err_o   = '0;
        itr_rty_o   = '0;
        full        = 1'b0;
        if (state == BUSY) begin
            full              = (cnt == CNT_MAX);
            tgt_cyc_o         = itr_cyc_i[last];
            tgt_lock_o        = itr_lock_i[last];
            tgt_stb_o         = itr_cyc_i[last] & itr_stb_i[last] & ~full;
            itr_stall_o[last] = tgt_stall_i | full;
            itr_ack_o[last]   = tgt_ack_i;
            itr_err_o[last]   = tgt_err_i;
            itr_rty_o[last]   = tgt_rty_i;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_wb_rr_arbiter;
    localparam int N   = 4;
    localparam int MAX = 4;

    logic         clk = 1'b0;
    logic         async_rst = 1'b1;
    logic         sync_rst = 1'b0;
    logic [N-1:0] cyc = '0, stb = '0, lock = '0;
    logic         t_ack = 1'b0, t_err = 1'b0, t_rty = 1'b0, t_stall = 1'b0;
    logic [N-1:0] itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o, gnt_o;
    logic         tgt_cyc_o, tgt_stb_o, tgt_lock_o;

    int checks = 0;
    int errors = 0;
    int acc_n;

    always #5 clk = ~clk;

    wb_rr_arbiter #(.ITR_CNT(N), .OUTSTD_MAX(MAX)) dut (
        .clk_i(clk), .async_rst_i(async_rst), .sync_rst_i(sync_rst),
        .itr_cyc_i(cyc), .itr_stb_i(stb), .itr_lock_i(lock),
        .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o), .itr_rty_o(itr_rty_o),
        .itr_stall_o(itr_stall_o),
        .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o), .tgt_lock_o(tgt_lock_o),
        .tgt_ack_i(t_ack), .tgt_err_i(t_err), .tgt_rty_i(t_rty), .tgt_stall_i(t_stall),
        .gnt_o(gnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: grantee index (-1 = nobody), last winner, outstanding count.
    int m_g = -1;
    int m_last = N - 1;
    int m_cnt = 0;

    function automatic bit m_stb();
        if (m_g < 0) return 1'b0;
        return cyc[m_g] && stb[m_g] && (m_cnt < MAX);
    endfunction

    always @(posedge clk or posedge async_rst) begin
        if (async_rst || sync_rst) begin
            m_g = -1; m_last = N - 1; m_cnt = 0;
        end else if (m_g < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (cyc[(m_last + k) % N]) begin
                    m_g = (m_last + k) % N;
                    m_last = m_g;
                    m_cnt = 0;
                    break;
                end
            end
        end else if (!cyc[m_g]) begin
            m_g = -1; m_cnt = 0;
        end else begin
            bit a, r;
            a = m_stb() && !t_stall;
            r = t_ack || t_err || t_rty;
            if (a && !r) m_cnt++;
            else if (r && !a && m_cnt > 0) m_cnt--;
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] e_gnt, e_stall, e_ack, e_err, e_rty;
        logic [2:0]   e_tgt;
        e_gnt = '0; e_stall = '1; e_ack = '0; e_err = '0; e_rty = '0; e_tgt = '0;
        if (m_g >= 0) begin
            e_gnt[m_g]   = 1'b1;
            e_stall[m_g] = t_stall || (m_cnt == MAX);
            e_ack[m_g]   = t_ack;
            e_err[m_g]   = t_err;
            e_rty[m_g]   = t_rty;
            e_tgt        = {cyc[m_g], m_stb(), lock[m_g]};
        end
        check("gnt", gnt_o, e_gnt);
        check("tgt_cyc_stb_lock", {tgt_cyc_o, tgt_stb_o, tgt_lock_o}, e_tgt);
        check("stall", itr_stall_o, e_stall);
        check("resp", {itr_ack_o, itr_err_o, itr_rty_o}, {e_ack, e_err, e_rty});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds current inputs for n cycles, counting accesses the target takes.
    task automatic run_count(input int n);
        acc_n = 0;
        repeat (n) begin
            #1;
            if (tgt_stb_o && !t_stall) acc_n++;
            step();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", gnt_o, 0);
        check("rst_tgt_cyc", tgt_cyc_o, 0);
        check("rst_stall", itr_stall_o, 4'b1111);
        async_rst = 1'b0;
        step(); step();
        check("idle_stall", itr_stall_o, 4'b1111);

        // Round robin between initiators 1 and 3
        cyc = 4'b1010; #1;
        check("req_cycle_stall", itr_stall_o, 4'b1111);
        check("req_cycle_gnt", gnt_o, 0);
        step();
        check("gnt_first", gnt_o, 4'b0010);
        check("model_g_first", m_g, 1);
        cyc = 4'b1000; step();
        check("release_gnt", gnt_o, 0);
        cyc = 4'b1010; step();
        check("gnt_second", gnt_o, 4'b1000);
        cyc = 4'b0010; step();
        check("release2_gnt", gnt_o, 0);
        cyc = 4'b1010; step();
        check("gnt_third", gnt_o, 4'b0010);
        cyc = 4'b0000; step(); step();

        // Outstanding limit with initiator 2
        cyc = 4'b0100; step();
        check("gnt_2", gnt_o, 4'b0100);
        stb = 4'b0100;
        run_count(6);
        check("accepted_max", acc_n, 4);
        check("full_stall", itr_stall_o, 4'b1111);
        check("full_no_stb", tgt_stb_o, 0);
        t_ack = 1'b1; #1;
        check("ack_routed", itr_ack_o, 4'b0100);
        step();
        t_ack = 1'b0; #1;
        check("fifth_stb", tgt_stb_o, 1);
        step();
        #1 check("refull_no_stb", tgt_stb_o, 0);
        stb = 4'b0000; t_ack = 1'b1; step(); step();
        stb = 4'b0100; #1;
        check("acc_and_ack_stb", tgt_stb_o, 1);
        step();
        t_ack = 1'b0;
        run_count(4);
        check("accepted_after_both", acc_n, 2);
        stb = 4'b0000; t_ack = 1'b1;
        repeat (4) step();
        #1 check("spurious_ack", itr_ack_o, 4'b0100);
        step();
        t_ack = 1'b0; stb = 4'b0100;
        run_count(6);
        check("accepted_after_spurious", acc_n, 4);

        // Drop cyc with three outstanding
        stb = 4'b0000; t_ack = 1'b1; step();
        t_ack = 1'b0; cyc = 4'b0000; step();
        check("drop_gnt", gnt_o, 0);
        check("model_cnt_drop", m_cnt, 0);
        t_ack = 1'b1; #1;
        check("late_ack_dropped", itr_ack_o, 4'b0000);
        step();
        t_ack = 1'b0;

        // Asynchronous then synchronous reset while busy
        cyc = 4'b0001; step();
        check("gnt_0", gnt_o, 4'b0001);
        #1 async_rst = 1'b1;
        #1;
        check("arst_gnt", gnt_o, 0);
        check("arst_tgt_cyc", tgt_cyc_o, 0);
        async_rst = 1'b0;
        step();
        check("regnt_after_arst", gnt_o, 4'b0001);
        sync_rst = 1'b1; #1;
        check("srst_before_edge", gnt_o, 4'b0001);
        step();
        check("srst_gnt", gnt_o, 0);
        check("srst_tgt_cyc", tgt_cyc_o, 0);
        sync_rst = 1'b0; cyc = 4'b0000; step();

        // Random traffic
        repeat (3000) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) cyc[i] = ~cyc[i];
            stb      = N'($urandom);
            lock     = N'($urandom);
            t_stall  = ($urandom_range(9) < 3);
            t_ack    = ($urandom_range(3) == 0);
            t_err    = ($urandom_range(19) == 0);
            t_rty    = ($urandom_range(19) == 0);
            sync_rst = ($urandom_range(199) == 0);
            if ($urandom_range(499) == 0) begin
                #2 async_rst = 1'b1;
                #1 async_rst = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
